// File: rtl/shift_ctrl_pkg.sv
// Shared constants for the bidirectional shift register command sequencer:
// opcodes, register mode encodings and the controller state encoding.
package shift_ctrl_pkg;

   localparam int SR_WIDTH = 4;
   localparam int SR_CNT_W = 3;

   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_LOAD  = 3'b001;
   localparam logic [2:0] OP_SHR   = 3'b010;
   localparam logic [2:0] OP_SHL   = 3'b011;
   localparam logic [2:0] OP_ROR   = 3'b100;
   localparam logic [2:0] OP_ROL   = 3'b101;
   localparam logic [2:0] OP_ASR   = 3'b110;
   localparam logic [2:0] OP_CLEAR = 3'b111;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/shift_register_controller.sv
// Command sequencer for an external bi_shift_register: accepts one command,
// drives the register's mode and serial/parallel inputs, then captures the result.
module shift_register_controller
   import shift_ctrl_pkg::*;
#(
   parameter int WIDTH = SR_WIDTH,
   parameter int CNT_W = SR_CNT_W
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             serial_in,
   output logic [1:0]       sr_S,
   output logic             sr_right_in,
   output logic             sr_left_in,
   output logic [WIDTH-1:0] sr_data_in,
   input  logic [WIDTH-1:0] sr_data_out,
   output logic             serial_out,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   state_t           r_state;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_data;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_result;

   // The down-counter doubles as the latched shift count; it is loaded on every accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_op     <= '0;
         r_data   <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_op   <= cmd_op;
                  r_data <= cmd_data;
                  r_cnt  <= cmd_count;
                  if (cmd_op == OP_LOAD || cmd_op == OP_CLEAR) begin
                     r_state <= ST_LOAD;
                  end else if (cmd_op == OP_NOP || cmd_count == '0) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_state <= ST_SHIFT;
                  end
               end
            end
            ST_LOAD: begin
               r_state <= ST_DONE;
            end
            ST_SHIFT: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_result <= sr_data_out;
               r_state  <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Rotates and ASR feed a bit of the register's current value back into the vacated end.
   always_comb begin
      sr_S        = MODE_HOLD;
      sr_right_in = 1'b0;
      sr_left_in  = 1'b0;
      sr_data_in  = '0;
      serial_out  = 1'b0;
      case (r_state)
         ST_LOAD: begin
            sr_S = MODE_LOAD;
            if (r_op == OP_LOAD) begin
               sr_data_in = r_data;
            end
         end
         ST_SHIFT: begin
            case (r_op)
               OP_SHR: begin
                  sr_S        = MODE_SHR;
                  sr_right_in = serial_in;
                  serial_out  = sr_data_out[0];
               end
               OP_SHL: begin
                  sr_S        = MODE_SHL;
                  sr_left_in  = serial_in;
                  serial_out  = sr_data_out[WIDTH-1];
               end
               OP_ROR: begin
                  sr_S        = MODE_SHR;
                  sr_right_in = sr_data_out[0];
                  serial_out  = sr_data_out[0];
               end
               OP_ROL: begin
                  sr_S        = MODE_SHL;
                  sr_left_in  = sr_data_out[WIDTH-1];
                  serial_out  = sr_data_out[WIDTH-1];
               end
               OP_ASR: begin
                  sr_S        = MODE_SHR;
                  sr_right_in = sr_data_out[WIDTH-1];
                  serial_out  = sr_data_out[0];
               end
               default: begin
                  sr_S = MODE_HOLD;
               end
            endcase
         end
         default: begin
            sr_S = MODE_HOLD;
         end
      endcase
   end

   assign cmd_ready = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign done      = (r_state == ST_DONE);
   assign result    = r_result;

endmodule

// File: tb/tb_shift_register_controller.sv
// Bench for shift_register_controller: the 4-bit register sits beside the DUT as
// in the system wrapper, and an arithmetic model predicts every command's outcome.
module tb_shift_register_controller;
   import shift_ctrl_pkg::*;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [2:0] cmd_count;
   logic [3:0] cmd_data;
   logic       serial_in;
   logic [1:0] sr_S;
   logic       sr_right_in;
   logic       sr_left_in;
   logic [3:0] sr_data_in;
   logic [3:0] sr_data_out;
   logic       serial_out;
   logic       busy;
   logic       done;
   logic [3:0] result;

   int passCount;
   int checkCount;

   logic       rstN;
   logic [3:0] regQ;

   shift_register_controller #(.WIDTH(4), .CNT_W(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_count   (cmd_count),
      .cmd_data    (cmd_data),
      .serial_in   (serial_in),
      .sr_S        (sr_S),
      .sr_right_in (sr_right_in),
      .sr_left_in  (sr_left_in),
      .sr_data_in  (sr_data_in),
      .sr_data_out (sr_data_out),
      .serial_out  (serial_out),
      .busy        (busy),
      .done        (done),
      .result      (result)
   );

   // The neighbouring bi_shift_register, reset active-low from ~rst like the wrapper does.
   assign rstN = ~rst;
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         regQ <= 4'b0000;
      end else begin
         case (sr_S)
            2'b01:   regQ <= {sr_right_in, regQ[3:1]};
            2'b10:   regQ <= {regQ[2:0], sr_left_in};
            2'b11:   regQ <= sr_data_in;
            default: regQ <= regQ;
         endcase
      end
   end
   assign sr_data_out = regQ;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the value after one shift and the bit that leaves during it.
   function automatic logic [3:0] modelStep(input logic [2:0] op, input logic [3:0] v, input logic sin);
      int x;
      int s;
      x = int'(v);
      s = int'(sin);
      case (op)
         OP_SHR:  x = (x / 2) + 8 * s;
         OP_SHL:  x = ((x * 2) % 16) + s;
         OP_ROR:  x = (x / 2) + 8 * (x % 2);
         OP_ROL:  x = ((x * 2) % 16) + (x / 8);
         OP_ASR:  x = (x / 2) + (x / 8) * 8;
         default: x = x;
      endcase
      return 4'(x);
   endfunction

   function automatic logic modelLeave(input logic [2:0] op, input logic [3:0] v);
      if (op == OP_SHL || op == OP_ROL) return 1'(int'(v) / 8);
      return 1'(int'(v) % 2);
   endfunction

   // Presents a command from a negedge and returns 1 ns after the accepting edge.
   task automatic sendCmd(input logic [2:0] op, input logic [2:0] cnt, input logic [3:0] dat, input logic sin);
      int waitCycles;
      waitCycles = 0;
      while (!cmd_ready && waitCycles < 50) begin
         @(negedge clk);
         waitCycles++;
      end
      if (!cmd_ready) begin
         checkCount++;
         $display("[TB] FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, waitCycles);
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_count = cnt;
      cmd_data  = dat;
      serial_in = sin;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic loadReg(input logic [3:0] dat);
      sendCmd(OP_LOAD, 3'd0, dat, 1'b0);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checkCount++;
      if ({cmd_ready, busy, done, sr_S, serial_out} !== 6'b100000)
         $display("[TB] FAIL reset_outputs: ready/busy/done/S/sout=%b required 100000",
                  {cmd_ready, busy, done, sr_S, serial_out});
      else passCount++;
      checkCount++;
      if (result !== 4'b0000) $display("[TB] FAIL reset_result: got %b required 0000", result);
      else passCount++;
      rst = 1'b0;
      @(negedge clk);
      checkCount++;
      if ({cmd_ready, busy, done} !== 3'b100)
         $display("[TB] FAIL reset_release: ready/busy/done=%b required 100", {cmd_ready, busy, done});
      else passCount++;
   endtask

   task automatic test_load();
      sendCmd(OP_LOAD, 3'd0, 4'b1011, 1'b0);
      @(negedge clk);
      checkCount++;
      if ({sr_S, sr_data_in} !== 6'b111011)
         $display("[TB] FAIL load_drive: S/data_in=%b required 111011", {sr_S, sr_data_in});
      else passCount++;
      @(negedge clk);
      checkCount++;
      if ({done, cmd_ready, sr_S, regQ} !== 8'b10001011)
         $display("[TB] FAIL load_done: done/ready/S/reg=%b required 10001011", {done, cmd_ready, sr_S, regQ});
      else passCount++;
      @(negedge clk);
      checkCount++;
      if ({result, cmd_ready, done} !== 6'b101110)
         $display("[TB] FAIL load_result: result/ready/done=%b required 101110", {result, cmd_ready, done});
      else passCount++;
   endtask

   task automatic test_rotate_right();
      logic [3:0] expSeq [3] = '{4'b1101, 4'b1110, 4'b0111};
      logic       expOut [3] = '{1'b1, 1'b1, 1'b0};
      loadReg(4'b1011);
      sendCmd(OP_ROR, 3'd3, 4'b0000, 1'b0);
      for (int k = 0; k <= 3; k++) begin
         @(negedge clk);
         if (k > 0) begin
            checkCount++;
            if (regQ !== expSeq[k-1]) $display("[TB] FAIL ror_seq%0d: got %b required %b", k, regQ, expSeq[k-1]);
            else passCount++;
         end
         if (k < 3) begin
            checkCount++;
            if ({sr_S, serial_out} !== {2'b01, expOut[k]})
               $display("[TB] FAIL ror_cycle%0d: S/sout=%b required %b", k, {sr_S, serial_out}, {2'b01, expOut[k]});
            else passCount++;
         end
      end
      checkCount++;
      if (done !== 1'b1) $display("[TB] FAIL ror_done: got %b required 1", done);
      else passCount++;
      @(negedge clk);
      checkCount++;
      if (result !== 4'b0111) $display("[TB] FAIL ror_result: got %b required 0111", result);
      else passCount++;
   endtask

   task automatic test_shift_left();
      logic [3:0] expSeq [2] = '{4'b0011, 4'b0111};
      logic       expOut [2] = '{1'b1, 1'b0};
      loadReg(4'b1001);
      sendCmd(OP_SHL, 3'd2, 4'b0000, 1'b1);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checkCount++;
         if ({sr_S, serial_out} !== {2'b10, expOut[k]})
            $display("[TB] FAIL shl_cycle%0d: S/sout=%b required %b", k, {sr_S, serial_out}, {2'b10, expOut[k]});
         else passCount++;
      end
      @(negedge clk);
      checkCount++;
      if ({done, regQ} !== {1'b1, expSeq[1]})
         $display("[TB] FAIL shl_done: done/reg=%b required %b", {done, regQ}, {1'b1, expSeq[1]});
      else passCount++;
      @(negedge clk);
      checkCount++;
      if (result !== 4'b0111) $display("[TB] FAIL shl_result: got %b required 0111", result);
      else passCount++;
      serial_in = 1'b0;
   endtask

   task automatic test_asr_zero_count();
      loadReg(4'b1000);
      sendCmd(OP_ASR, 3'd2, 4'b0000, 1'b0);
      repeat (3) @(negedge clk);
      checkCount++;
      if ({done, regQ} !== 5'b11110) $display("[TB] FAIL asr_done: done/reg=%b required 11110", {done, regQ});
      else passCount++;
      @(negedge clk);
      checkCount++;
      if (result !== 4'b1110) $display("[TB] FAIL asr_result: got %b required 1110", result);
      else passCount++;
      sendCmd(OP_ROL, 3'd0, 4'b0000, 1'b0);
      @(negedge clk);
      checkCount++;
      if ({done, sr_S, regQ} !== 7'b1001110)
         $display("[TB] FAIL rol0_done: done/S/reg=%b required 1001110", {done, sr_S, regQ});
      else passCount++;
      @(negedge clk);
      checkCount++;
      if ({result, cmd_ready} !== 5'b11101) $display("[TB] FAIL rol0_result: result/ready=%b required 11101", {result, cmd_ready});
      else passCount++;
   endtask

   task automatic test_busy_ignore();
      int busyCycles;
      int donePulses;
      sendCmd(OP_SHR, 3'd7, 4'b0000, 1'b1);
      cmd_valid  = 1'b1;
      cmd_op     = OP_LOAD;
      cmd_data   = 4'b0000;
      busyCycles = 0;
      donePulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!busy) break;
         busyCycles++;
         if (done) donePulses++;
      end
      checkCount++;
      if (busyCycles != 8) $display("[TB] FAIL busy_length: got %0d cycles required 8", busyCycles);
      else passCount++;
      checkCount++;
      if (donePulses != 1) $display("[TB] FAIL busy_done_pulses: got %0d required 1", donePulses);
      else passCount++;
      checkCount++;
      if ({result, cmd_ready} !== 5'b11111) $display("[TB] FAIL busy_result: result/ready=%b required 11111", {result, cmd_ready});
      else passCount++;
      @(negedge clk);
      cmd_valid = 1'b0;
      checkCount++;
      if (sr_S !== 2'b11) $display("[TB] FAIL held_cmd_accept: S=%b required 11", sr_S);
      else passCount++;
      repeat (2) @(negedge clk);
      checkCount++;
      if ({result, regQ} !== 8'b00000000) $display("[TB] FAIL held_cmd_result: result/reg=%b required 00000000", {result, regQ});
      else passCount++;
      serial_in = 1'b0;
   endtask

   task automatic test_reset_mid_op();
      int donePulses;
      loadReg(4'b0110);
      sendCmd(OP_ROL, 3'd5, 4'b0000, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkCount++;
      if ({sr_S, busy, cmd_ready, done} !== 5'b00010)
         $display("[TB] FAIL midreset_async: S/busy/ready/done=%b required 00010", {sr_S, busy, cmd_ready, done});
      else passCount++;
      donePulses = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (done) donePulses++;
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) donePulses++;
      end
      checkCount++;
      if (donePulses != 0) $display("[TB] FAIL midreset_done: got %0d pulses required 0", donePulses);
      else passCount++;
      checkCount++;
      if ({result, cmd_ready, busy} !== 6'b000010)
         $display("[TB] FAIL midreset_after: result/ready/busy=%b required 000010", {result, cmd_ready, busy});
      else passCount++;
   endtask

   // Random command stream issued back-to-back on the first cycle cmd_ready is seen.
   task automatic test_random();
      logic [3:0] v;
      logic [2:0] op;
      logic [2:0] cnt;
      logic [3:0] dat;
      logic       sin;
      logic [1:0] expMode;
      loadReg(4'b0101);
      v = 4'b0101;
      for (int t = 0; t < 40; t++) begin
         op  = 3'($urandom_range(0, 7));
         cnt = 3'($urandom_range(0, 7));
         dat = 4'($urandom);
         sin = 1'($urandom);
         sendCmd(op, cnt, dat, sin);
         if (op == OP_LOAD || op == OP_CLEAR) begin
            @(negedge clk);
            if (op == OP_CLEAR) dat = 4'b0000;
            checkCount++;
            if ({sr_S, sr_data_in} !== {2'b11, dat})
               $display("[TB] FAIL rand%0d_load: S/data_in=%b required %b", t, {sr_S, sr_data_in}, {2'b11, dat});
            else passCount++;
            v = dat;
         end else if (op != OP_NOP && cnt != 3'd0) begin
            expMode = (op == OP_SHL || op == OP_ROL) ? 2'b10 : 2'b01;
            for (int k = 0; k < int'(cnt); k++) begin
               @(negedge clk);
               checkCount++;
               if ({busy, sr_S, serial_out} !== {1'b1, expMode, modelLeave(op, v)})
                  $display("[TB] FAIL rand%0d_shift%0d op=%0d: busy/S/sout=%b required %b", t, k, op,
                           {busy, sr_S, serial_out}, {1'b1, expMode, modelLeave(op, v)});
               else passCount++;
               v = modelStep(op, v, sin);
            end
         end
         @(negedge clk);
         checkCount++;
         if ({done, sr_S, serial_out, regQ} !== {4'b1000, v})
            $display("[TB] FAIL rand%0d_done op=%0d cnt=%0d: done/S/sout/reg=%b required %b", t, op, cnt,
                     {done, sr_S, serial_out, regQ}, {4'b1000, v});
         else passCount++;
         @(negedge clk);
         checkCount++;
         if ({result, cmd_ready, done} !== {v, 2'b10})
            $display("[TB] FAIL rand%0d_result: result/ready/done=%b required %b", t, {result, cmd_ready, done}, {v, 2'b10});
         else passCount++;
      end
   endtask

   initial begin
      passCount  = 0;
      checkCount = 0;
      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_op     = 3'b000;
      cmd_count  = 3'd0;
      cmd_data   = 4'b0000;
      serial_in  = 1'b0;
      test_reset();
      test_load();
      test_rotate_right();
      test_shift_left();
      test_asr_zero_count();
      test_busy_ignore();
      test_reset_mid_op();
      test_random();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
